// File: rtl/fetch_stage_ctrl_if.sv
// Bundle of the fetch controller's run-control, hazard, redirect and IF/ID signals.
// The master side is the surrounding pipeline; the slave side is fetch_stage_ctrl.
interface fetch_stage_ctrl_if #(
  parameter int unsigned DATA_W = 32
);
  logic              i_enable;
  logic              i_stall_pc_HD;
  logic              i_stall_if_id_HD;
  logic              i_pc_src_D;
  logic [DATA_W-1:0] i_branch_target_D;
  logic [DATA_W-1:0] i_instr_IF;
  logic [DATA_W-1:0] o_pc;
  logic [DATA_W-1:0] o_instr_D;
  logic [DATA_W-1:0] o_pc_plus4_D;
  logic              o_halt;
  logic [31:0]       o_stall_cycles;
  logic [31:0]       o_flush_cycles;

  modport master (
    output i_enable, i_stall_pc_HD, i_stall_if_id_HD, i_pc_src_D,
           i_branch_target_D, i_instr_IF,
    input  o_pc, o_instr_D, o_pc_plus4_D, o_halt, o_stall_cycles, o_flush_cycles
  );

  modport slave (
    input  i_enable, i_stall_pc_HD, i_stall_if_id_HD, i_pc_src_D,
           i_branch_target_D, i_instr_IF,
    output o_pc, o_instr_D, o_pc_plus4_D, o_halt, o_stall_cycles, o_flush_cycles
  );
endinterface

// File: rtl/fetch_stage_ctrl.sv
// PC and IF/ID register owner with stall/redirect/flush priority and halt drain.
// Optional performance counters are built only when FETCH_PERF_CNT_EN is defined.
module fetch_stage_ctrl #(
  parameter int unsigned       DATA_W       = 32,
  parameter logic [DATA_W-1:0] RESET_PC     = '0,
  parameter logic [DATA_W-1:0] HALT_OPCODE  = '1,
  parameter int unsigned       DRAIN_CYCLES = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  fetch_stage_ctrl_if.slave bus
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] pc4_q, pc4_d;
  logic [31:0]       drain_q, drain_d;
  logic              halt_q;
  logic [DATA_W-1:0] pc_plus4;

  assign pc_plus4 = pc_q + DATA_W'(4);

  // NOTE: every variable gets its hold value first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    drain_d = drain_q;
    if (bus.i_enable) begin
      case (state_q)
        ST_RUN: begin
          if (!bus.i_stall_pc_HD) begin
            pc_d = bus.i_pc_src_D ? bus.i_branch_target_D : pc_plus4;
          end
          if (!bus.i_stall_if_id_HD) begin
            if (bus.i_pc_src_D) begin
              instr_d = '0;
              pc4_d   = '0;
            end else begin
              instr_d = bus.i_instr_IF;
              pc4_d   = pc_plus4;
              // Only a halt word that actually lands in IF/ID starts the drain.
              if (bus.i_instr_IF == HALT_OPCODE) begin
                state_d = ST_DRAIN;
                drain_d = '0;
              end
            end
          end
        end
        ST_DRAIN: begin
          if (!bus.i_stall_if_id_HD) begin
            instr_d = '0;
            pc4_d   = '0;
            drain_d = drain_q + 32'd1;
            if (drain_d >= 32'(DRAIN_CYCLES)) begin
              state_d = ST_HALTED;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pc4_q   <= '0;
      drain_q <= '0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      drain_q <= drain_d;
      halt_q  <= (state_d == ST_HALTED);
    end
  end

  assign bus.o_pc         = pc_q;
  assign bus.o_instr_D    = instr_q;
  assign bus.o_pc_plus4_D = pc4_q;
  assign bus.o_halt       = halt_q;

`ifdef FETCH_PERF_CNT_EN
  logic        run_en;
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  assign run_en = bus.i_enable && (state_q == ST_RUN);

  // Both counters saturate rather than wrap.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (run_en && bus.i_stall_pc_HD && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (run_en && !bus.i_stall_if_id_HD && bus.i_pc_src_D && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign bus.o_stall_cycles = stall_cnt_q;
  assign bus.o_flush_cycles = flush_cnt_q;
`else
  assign bus.o_stall_cycles = '0;
  assign bus.o_flush_cycles = '0;
`endif

endmodule
